// File: rtl/grf_scoreboard_pkg.sv
// Shared types and constants for the register file with a pending-write scoreboard.
package grf_scoreboard_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [WIDTH-1:0]  word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Register $0 is hardwired: it can never hold data nor be pending.
    function automatic logic is_live(input reg_idx_t idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/grf_scoreboard_if.sv
// Read/write/issue bus between the issue stage and the register file.
interface grf_scoreboard_if
    import grf_scoreboard_pkg::*;
();
    reg_idx_t A1;
    reg_idx_t A2;
    word_t    RD1;
    word_t    RD2;
    logic     busy1;
    logic     busy2;
    reg_idx_t A3;
    word_t    WD;
    logic     WE;
    logic     issue_en;
    reg_idx_t issue_dst;

    modport master (
        output A1, A2, A3, WD, WE, issue_en, issue_dst,
        input  RD1, RD2, busy1, busy2
    );

    modport slave (
        input  A1, A2, A3, WD, WE, issue_en, issue_dst,
        output RD1, RD2, busy1, busy2
    );
endinterface

// File: rtl/grf_scoreboard_scoreboard.sv
// Pending-write bit per register, with issue/writeback update and busy lookup.
module grf_scoreboard_scoreboard
    import grf_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  reg_idx_t i_a1,
    input  reg_idx_t i_a2,
    input  reg_idx_t i_a3,
    input  logic     i_we,
    input  logic     i_issue_en,
    input  reg_idx_t i_issue_dst,
    output logic     o_busy1_c,
    output logic     o_busy2_c
);

    logic [NREG-1:0] r_pend;
    logic            w_wb_live;
    logic            w_issue_live;

    assign w_wb_live    = i_we && is_live(i_a3);
    assign w_issue_live = i_issue_en && is_live(i_issue_dst);

    // Writeback clears, issue sets; issue is applied last so a new producer wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            if (w_wb_live) begin
                r_pend[i_a3] <= 1'b0;
            end
            if (w_issue_live) begin
                r_pend[i_issue_dst] <= 1'b1;
            end
        end
    end

    // A read being bypassed from this cycle's writeback is not busy.
    always_comb begin
        o_busy1_c = 1'b0;
        o_busy2_c = 1'b0;
        if (is_live(i_a1)) begin
            o_busy1_c = r_pend[i_a1] && !(i_we && (i_a3 == i_a1));
        end
        if (is_live(i_a2)) begin
            o_busy2_c = r_pend[i_a2] && !(i_we && (i_a3 == i_a2));
        end
    end

endmodule

// File: rtl/grf_scoreboard.sv
// 32x32 register file with two bypassed read ports, one write port and a scoreboard.
module grf_scoreboard
    import grf_scoreboard_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    grf_scoreboard_if.slave bus
);

    word_t r_regs [NREG];
    word_t w_rd1;
    word_t w_rd2;
    logic  w_busy1;
    logic  w_busy2;
    logic  w_wr_live;

    assign w_wr_live = bus.WE && is_live(bus.A3);

    // Storage update; entry 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs <= '{default: '0};
        end else if (w_wr_live) begin
            r_regs[bus.A3] <= bus.WD;
        end
    end

    // Combinational reads with same-cycle write bypass.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (is_live(bus.A1)) begin
            w_rd1 = (w_wr_live && (bus.A3 == bus.A1)) ? bus.WD : r_regs[bus.A1];
        end
        if (is_live(bus.A2)) begin
            w_rd2 = (w_wr_live && (bus.A3 == bus.A2)) ? bus.WD : r_regs[bus.A2];
        end
    end

    grf_scoreboard_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .i_a1        (bus.A1),
        .i_a2        (bus.A2),
        .i_a3        (bus.A3),
        .i_we        (bus.WE),
        .i_issue_en  (bus.issue_en),
        .i_issue_dst (bus.issue_dst),
        .o_busy1_c   (w_busy1),
        .o_busy2_c   (w_busy2)
    );

    assign bus.RD1   = w_rd1;
    assign bus.RD2   = w_rd2;
    assign bus.busy1 = w_busy1;
    assign bus.busy2 = w_busy2;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed vector table plus randomized run against a behavioural register-file model.
module tb_grf_scoreboard;
    import grf_scoreboard_pkg::*;

    typedef struct {
        logic     rst;
        reg_idx_t a1;
        reg_idx_t a2;
        reg_idx_t a3;
        word_t    wd;
        logic     we;
        logic     ien;
        reg_idx_t idst;
        word_t    rd1;
        word_t    rd2;
        logic     b1;
        logic     b2;
    } vec_t;

    localparam int unsigned NVEC  = 26;
    localparam int unsigned NRAND = 1500;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    word_t m_regs [NREG];
    logic  m_pend [NREG];
    vec_t  tbl [NVEC];

    grf_scoreboard_if bus ();

    grf_scoreboard u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int unsigned rst, input int unsigned a1,
                                input int unsigned a2, input int unsigned a3,
                                input int unsigned wd, input int unsigned we,
                                input int unsigned ien, input int unsigned idst,
                                input int unsigned rd1, input int unsigned rd2,
                                input int unsigned b1, input int unsigned b2);
        vec_t v;
        v.rst  = 1'(rst);
        v.a1   = 5'(a1);
        v.a2   = 5'(a2);
        v.a3   = 5'(a3);
        v.wd   = 32'(wd);
        v.we   = 1'(we);
        v.ien  = 1'(ien);
        v.idst = 5'(idst);
        v.rd1  = 32'(rd1);
        v.rd2  = 32'(rd2);
        v.b1   = 1'(b1);
        v.b2   = 1'(b2);
        return v;
    endfunction

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model reads straight from the rules: $0 is zero, live write bypasses, else storage.
    function automatic word_t m_rd(input reg_idx_t a);
        if (a == 5'd0) return '0;
        if (bus.WE && bus.A3 == a) return bus.WD;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input reg_idx_t a);
        if (a == 5'd0) return 1'b0;
        return m_pend[a] && !(bus.WE && bus.A3 == a);
    endfunction

    task automatic drive(input logic rst, input reg_idx_t a1, input reg_idx_t a2,
                         input reg_idx_t a3, input word_t wd, input logic we,
                         input logic ien, input reg_idx_t idst);
        reset         = rst;
        bus.A1        = a1;
        bus.A2        = a2;
        bus.A3        = a3;
        bus.WD        = wd;
        bus.WE        = we;
        bus.issue_en  = ien;
        bus.issue_dst = idst;
        @(negedge clk);
    endtask

    // Advance one edge and apply the same edge to the model.
    task automatic commit();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (bus.WE && bus.A3 != 5'd0) begin
                m_regs[bus.A3] = bus.WD;
                m_pend[bus.A3] = 1'b0;
            end
            if (bus.issue_en && bus.issue_dst != 5'd0) begin
                m_pend[bus.issue_dst] = 1'b1;
            end
        end
        #1;
    endtask

    function automatic reg_idx_t rnd_idx();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        clk   = 1'b0;
        total = 0;
        bad   = 0;

        // rst a1 a2 a3 wd we ien idst | rd1 rd2 b1 b2
        tbl[0]  = mk(0,  5, 31,  0, 0,            0, 0,  0,  0,            0,    0, 0);
        tbl[1]  = mk(0,  8,  0,  8, 32'hDEADBEEF, 1, 0,  0,  32'hDEADBEEF, 0,    0, 0);
        tbl[2]  = mk(0,  8,  0,  0, 32'h1234,     1, 0,  0,  32'hDEADBEEF, 0,    0, 0);
        tbl[3]  = mk(0,  0,  0,  0, 0,            0, 0,  0,  0,            0,    0, 0);
        tbl[4]  = mk(0,  9,  0,  9, 32'h1,        1, 0,  0,  32'h1,        0,    0, 0);
        tbl[5]  = mk(0,  9,  9,  9, 32'h55,       1, 0,  0,  32'h55,       32'h55, 0, 0);
        tbl[6]  = mk(0,  9,  0,  0, 0,            0, 0,  0,  32'h55,       0,    0, 0);
        tbl[7]  = mk(0, 12,  0,  0, 0,            0, 1, 12,  0,            0,    0, 0);
        tbl[8]  = mk(0, 12, 12,  0, 0,            0, 0,  0,  0,            0,    1, 1);
        tbl[9]  = mk(0, 12, 12, 12, 7,            1, 0,  0,  7,            7,    0, 0);
        tbl[10] = mk(0, 12,  0,  0, 0,            0, 0,  0,  7,            0,    0, 0);
        tbl[11] = mk(0,  4,  0,  0, 0,            0, 1,  4,  0,            0,    0, 0);
        tbl[12] = mk(0,  4,  0,  4, 32'hAA,       1, 1,  4,  32'hAA,       0,    0, 0);
        tbl[13] = mk(0,  4,  6,  0, 0,            0, 0,  0,  32'hAA,       0,    1, 0);
        tbl[14] = mk(0,  4,  6,  4, 32'hBB,       1, 1,  6,  32'hBB,       0,    0, 0);
        tbl[15] = mk(0,  4,  6,  0, 0,            0, 0,  0,  32'hBB,       0,    0, 1);
        tbl[16] = mk(0,  3,  0,  3, 32'hA,        1, 1,  3,  32'hA,        0,    0, 0);
        tbl[17] = mk(0,  3,  7,  0, 0,            0, 1,  7,  32'hA,        0,    1, 0);
        tbl[18] = mk(1,  3,  7,  7, 32'h77,       1, 0,  0,  32'hA,        32'h77, 1, 0);
        tbl[19] = mk(0,  3,  7,  0, 0,            0, 0,  0,  0,            0,    0, 0);
        tbl[20] = mk(0, 12,  6,  0, 0,            0, 0,  0,  0,            0,    0, 0);
        tbl[21] = mk(0,  4,  9,  0, 0,            0, 0,  0,  0,            0,    0, 0);
        tbl[22] = mk(0,  0,  0,  0, 0,            0, 1,  5,  0,            0,    0, 0);
        tbl[23] = mk(0,  5,  0,  0, 0,            0, 1,  5,  0,            0,    1, 0);
        tbl[24] = mk(0, 31,  5,  5, 5,            1, 0,  0,  0,            5,    0, 0);
        tbl[25] = mk(0,  0,  5,  0, 0,            0, 0,  0,  0,            5,    0, 0);

        // Initial reset cycle; storage is unknown before it, so nothing is compared.
        drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, '0);
        commit();

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].rst, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].wd,
                  tbl[i].we, tbl[i].ien, tbl[i].idst);
            check($sformatf("vec%0d.RD1", i), bus.RD1, tbl[i].rd1);
            check($sformatf("vec%0d.RD2", i), bus.RD2, tbl[i].rd2);
            check($sformatf("vec%0d.busy1", i), 32'(bus.busy1), 32'(tbl[i].b1));
            check($sformatf("vec%0d.busy2", i), 32'(bus.busy2), 32'(tbl[i].b2));
            commit();
        end

        for (int n = 0; n < int'(NRAND); n++) begin
            drive(1'($urandom_range(0, 63) == 0), rnd_idx(), rnd_idx(), rnd_idx(),
                  32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rnd_idx());
            check($sformatf("rnd%0d.RD1", n), bus.RD1, m_rd(bus.A1));
            check($sformatf("rnd%0d.RD2", n), bus.RD2, m_rd(bus.A2));
            check($sformatf("rnd%0d.busy1", n), 32'(bus.busy1), 32'(m_busy(bus.A1)));
            check($sformatf("rnd%0d.busy2", n), 32'(bus.busy2), 32'(m_busy(bus.A2)));
            commit();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
